lcd_sprite_writer: RTL and testbench

- Parametrised successor to the single-object LCD writer: draws a SPRITE_ROWS x SPRITE_W block of CGRAM characters at any (col,row) on a 2x16 HD44780-style character LCD.
- Runs LCD init once after reset, then per request erases the old image (full clear or selective blanking of the previous footprint) and draws the new one.
- Sits between game logic (start/busy/done handshake) and the LCD pins; cells that fall off the right edge are clipped or wrapped.

---
 rtl/lcd_sprite_writer.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_lcd_sprite_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sprite_writer.sv
// Draws a SPRITE_ROWS x SPRITE_W block of CGRAM characters on a 2x16 HD44780-style LCD.
// Optional: define LCD_SPRITE_WRAP_EN to wrap cells past the right edge instead of clipping them.
module lcd_sprite_writer #(
  parameter int SPRITE_W    = 3,
  parameter int SPRITE_ROWS = 2,
  parameter int LCD_COLS    = 16,
  parameter int EN_HOLD     = 1,
  parameter int CMD_WAIT    = 2,
  parameter int CLEAR_WAIT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] col,
  input  logic       row,
  input  logic [7:0] base_char,
  input  logic       clear_mode,
  output logic       busy,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_PRE   = 3'd2,
    S_CLEAR = 3'd3,
    S_ERASE = 3'd4,
    S_DRAW  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_HOLD  = 2'd2,
    PH_WAIT  = 2'd3
  } phase_e;

  state_e     state_q, state_d;
  phase_e     ph_q, ph_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       en_q, en_d;
  logic       clr_tx_q, clr_tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       init_done_q, init_done_d;
  logic       prev_valid_q, prev_valid_d;
  logic [3:0] col_q, col_d;
  logic       row_q, row_d;
  logic [7:0] base_q, base_d;
  logic       mode_q, mode_d;
  logic [3:0] pcol_q, pcol_d;
  logic       prow_q, prow_d;
  logic [1:0] step_q, step_d;
  logic [1:0] r_q, r_d;
  logic [3:0] c_q, c_d;
  logic       half_q, half_d;

  logic [3:0] org_col_s;
  logic       org_row_s;
  logic [5:0] x_raw_s;
  logic [5:0] x_s;
  logic [1:0] line_s;
  logic       clip_s;
  logic [7:0] cmd_s;
  logic [7:0] code_s;
  logic [3:0] c_next_s;
  logic [1:0] r_next_s;
  logic       tx_free_s;
  logic       issue_s;
  logic [7:0] issue_data_s;
  logic       issue_rs_s;
  logic       issue_clr_s;

  // Geometry of the cell under the walk pointer; ERASE walks the previous footprint.
  always_comb begin
    if (state_q == S_ERASE) begin
      org_col_s = pcol_q;
      org_row_s = prow_q;
    end else begin
      org_col_s = col_q;
      org_row_s = row_q;
    end
    x_raw_s = {2'b00, org_col_s} + {2'b00, c_q};
    line_s  = {1'b0, org_row_s} + r_q;
`ifdef LCD_SPRITE_WRAP_EN
    if (x_raw_s >= 6'(LCD_COLS)) begin
      x_s = x_raw_s - 6'(LCD_COLS);
    end else begin
      x_s = x_raw_s;
    end
    clip_s = (line_s > 2'd1);
`else
    x_s    = x_raw_s;
    clip_s = (line_s > 2'd1) || (x_raw_s >= 6'(LCD_COLS));
`endif
    cmd_s  = 8'h80 | ((line_s[0] ? 8'h40 : 8'h00) + {2'b00, x_s});
    code_s = base_q + (8'(r_q) * 8'(SPRITE_W)) + {4'h0, c_q};
    if (c_q == 4'(SPRITE_W - 1)) begin
      c_next_s = 4'd0;
      r_next_s = r_q + 2'd1;
    end else begin
      c_next_s = c_q + 4'd1;
      r_next_s = r_q;
    end
  end

  // Strobe sequencer plus the control FSM that feeds it one transaction at a time.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    rs_d         = rs_q;
    en_d         = en_q;
    clr_tx_d     = clr_tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    init_done_d  = init_done_q;
    prev_valid_d = prev_valid_q;
    col_d        = col_q;
    row_d        = row_q;
    base_d       = base_q;
    mode_d       = mode_q;
    pcol_d       = pcol_q;
    prow_d       = prow_q;
    step_d       = step_q;
    r_d          = r_q;
    c_d          = c_q;
    half_d       = half_q;
    tx_free_s    = 1'b0;
    issue_s      = 1'b0;
    issue_data_s = 8'h00;
    issue_rs_s   = 1'b0;
    issue_clr_s  = 1'b0;

    case (ph_q)
      PH_IDLE: tx_free_s = 1'b1;
      PH_SETUP: begin
        en_d  = 1'b1;
        cnt_d = 8'(EN_HOLD - 1);
        ph_d  = PH_HOLD;
      end
      PH_HOLD: begin
        if (cnt_q == 8'd0) begin
          en_d  = 1'b0;
          ph_d  = PH_WAIT;
          cnt_d = clr_tx_q ? 8'(CLEAR_WAIT - 1) : 8'(CMD_WAIT - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PH_WAIT: begin
        if (cnt_q == 8'd0) begin
          ph_d      = PH_IDLE;
          tx_free_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ph_d = PH_IDLE;
    endcase

    if (tx_free_s) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            col_d   = col;
            row_d   = row;
            base_d  = base_char;
            mode_d  = clear_mode;
            busy_d  = 1'b1;
            step_d  = 2'd0;
            state_d = init_done_q ? S_PRE : S_INIT;
          end else begin
            busy_d = 1'b0;
          end
        end
        S_INIT: begin
          case (step_q)
            2'd0: begin
              issue_s      = 1'b1;
              issue_data_s = 8'h38;
              step_d       = 2'd1;
            end
            2'd1: begin
              issue_s      = 1'b1;
              issue_data_s = 8'h0C;
              step_d       = 2'd2;
            end
            2'd2: begin
              issue_s      = 1'b1;
              issue_data_s = 8'h06;
              step_d       = 2'd3;
            end
            default: begin
              init_done_d = 1'b1;
              state_d     = S_PRE;
            end
          endcase
        end
        S_PRE: begin
          r_d    = 2'd0;
          c_d    = 4'd0;
          half_d = 1'b0;
          step_d = 2'd0;
          if (mode_q) begin
            state_d = S_CLEAR;
          end else if (prev_valid_q) begin
            state_d = S_ERASE;
          end else begin
            state_d = S_DRAW;
          end
        end
        S_CLEAR: begin
          if (step_q == 2'd0) begin
            issue_s      = 1'b1;
            issue_data_s = 8'h01;
            issue_clr_s  = 1'b1;
            step_d       = 2'd1;
          end else begin
            state_d = S_DRAW;
          end
        end
        S_ERASE, S_DRAW: begin
          // Walk is finished only once the last strobe has fully completed.
          if (r_q == 2'(SPRITE_ROWS)) begin
            r_d    = 2'd0;
            c_d    = 4'd0;
            half_d = 1'b0;
            if (state_q == S_ERASE) begin
              state_d = S_DRAW;
            end else begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              busy_d       = 1'b0;
              pcol_d       = col_q;
              prow_d       = row_q;
              prev_valid_d = 1'b1;
            end
          end else if (clip_s) begin
            c_d = c_next_s;
            r_d = r_next_s;
          end else if (!half_q) begin
            issue_s      = 1'b1;
            issue_data_s = cmd_s;
            half_d       = 1'b1;
          end else begin
            issue_s      = 1'b1;
            issue_data_s = (state_q == S_ERASE) ? 8'h20 : code_s;
            issue_rs_s   = 1'b1;
            half_d       = 1'b0;
            c_d          = c_next_s;
            r_d          = r_next_s;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else begin
      busy_d = busy_q;
    end

    if (issue_s) begin
      data_d   = issue_data_s;
      rs_d     = issue_rs_s;
      clr_tx_d = issue_clr_s;
      en_d     = 1'b0;
      ph_d     = PH_SETUP;
    end else begin
      clr_tx_d = clr_tx_q;
    end
  end

  // State and output registers; reset also forgets init_done and the previous footprint.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ph_q         <= PH_IDLE;
      cnt_q        <= 8'd0;
      data_q       <= 8'd0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      clr_tx_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      init_done_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      col_q        <= 4'd0;
      row_q        <= 1'b0;
      base_q       <= 8'd0;
      mode_q       <= 1'b0;
      pcol_q       <= 4'd0;
      prow_q       <= 1'b0;
      step_q       <= 2'd0;
      r_q          <= 2'd0;
      c_q          <= 4'd0;
      half_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      clr_tx_q     <= clr_tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      init_done_q  <= init_done_d;
      prev_valid_q <= prev_valid_d;
      col_q        <= col_d;
      row_q        <= row_d;
      base_q       <= base_d;
      mode_q       <= mode_d;
      pcol_q       <= pcol_d;
      prow_q       <= prow_d;
      step_q       <= step_d;
      r_q          <= r_d;
      c_q          <= c_d;
      half_q       <= half_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;

endmodule

// File: tb/tb_lcd_sprite_writer.sv
// Directed bench for lcd_sprite_writer: bus sequences, handshake, reset and strobe timing.
module tb_lcd_sprite_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [3:0] col = 4'd0;
  logic       row = 1'b0;
  logic [7:0] base_char = 8'd0;
  logic       clear_mode = 1'b0;
  logic       busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  logic       busy2, done2, rs2, rw2, en2;
  logic [7:0] data2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] bus_log[$];
  int         done_cnt = 0;
  logic       en_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_sprite_writer u_dut (
    .clk(clk), .rst(rst), .start(start), .col(col), .row(row), .base_char(base_char),
    .clear_mode(clear_mode), .busy(busy), .done(done), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  lcd_sprite_writer #(.EN_HOLD(3), .CMD_WAIT(5), .CLEAR_WAIT(4)) u_dut_slow (
    .clk(clk), .rst(rst), .start(start2), .col(col), .row(row), .base_char(base_char),
    .clear_mode(clear_mode), .busy(busy2), .done(done2), .lcd_data(data2),
    .lcd_rs(rs2), .lcd_rw(rw2), .lcd_en(en2)
  );

  // Record {rs,data} at every rising edge of lcd_en, and count done pulses.
  always @(negedge clk) begin
    if (lcd_en && !en_prev) bus_log.push_back({lcd_rs, lcd_data});
    if (done) done_cnt <= done_cnt + 1;
    en_prev <= lcd_en;
  end

  task automatic request(input logic [3:0] c, input logic r, input logic [7:0] b,
                         input logic m, output bit timed_out);
    @(negedge clk);
    col = c; row = r; base_char = b; clear_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", lcd_data); end
    n_tests++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs got %b want 0", lcd_rs); end
    n_tests++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %b want 0", lcd_rw); end
    n_tests++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", lcd_en); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_draw();
    logic [8:0] exp[$];
    int idx0, d0;
    bit seen;
    exp = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080, 9'h100, 9'h081, 9'h101,
            9'h082, 9'h102, 9'h0C0, 9'h103, 9'h0C1, 9'h104, 9'h0C2, 9'h105};
    idx0 = bus_log.size(); d0 = done_cnt;
    @(negedge clk);
    col = 4'd0; row = 1'b0; base_char = 8'h00; clear_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy_rise got %b want 1", busy); end
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL first_done_timeout got 0 want 1"); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_at_done got %b want 0", busy); end
    repeat (20) @(negedge clk);
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL first_done_count got %0d want 1", done_cnt - d0); end
    n_tests++; if (bus_log.size() - idx0 != exp.size()) begin n_fail++; $display("FAIL first_len got %0d want %0d", bus_log.size() - idx0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (idx0 + i >= bus_log.size()) begin n_fail++; $display("FAIL first_seq[%0d] got none want %h", i, exp[i]); end
      else if (bus_log[idx0 + i] !== exp[i]) begin n_fail++; $display("FAIL first_seq[%0d] got %h want %h", i, bus_log[idx0 + i], exp[i]); end
    end
  endtask

  task automatic test_edge_clip();
    logic [8:0] exp[$];
    int idx0;
    bit to;
`ifdef LCD_SPRITE_WRAP_EN
    exp = '{9'h001, 9'h08E, 9'h110, 9'h08F, 9'h111, 9'h080, 9'h112,
            9'h0CE, 9'h113, 9'h0CF, 9'h114, 9'h0C0, 9'h115};
`else
    exp = '{9'h001, 9'h08E, 9'h110, 9'h08F, 9'h111, 9'h0CE, 9'h113, 9'h0CF, 9'h114};
`endif
    idx0 = bus_log.size();
    request(4'd14, 1'b0, 8'h10, 1'b1, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL edge_done_timeout got 0 want 1"); end
    @(negedge clk);
    n_tests++; if (bus_log.size() - idx0 != exp.size()) begin n_fail++; $display("FAIL edge_len got %0d want %0d", bus_log.size() - idx0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (idx0 + i >= bus_log.size()) begin n_fail++; $display("FAIL edge_seq[%0d] got none want %h", i, exp[i]); end
      else if (bus_log[idx0 + i] !== exp[i]) begin n_fail++; $display("FAIL edge_seq[%0d] got %h want %h", i, bus_log[idx0 + i], exp[i]); end
    end
  endtask

  task automatic test_bottom_clip();
    logic [8:0] exp[$];
    int idx0;
    bit to;
    exp = '{9'h001, 9'h0C0, 9'h140, 9'h0C1, 9'h141, 9'h0C2, 9'h142};
    idx0 = bus_log.size();
    request(4'd0, 1'b1, 8'h40, 1'b1, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL bottom_done_timeout got 0 want 1"); end
    @(negedge clk);
    n_tests++; if (bus_log.size() - idx0 != exp.size()) begin n_fail++; $display("FAIL bottom_len got %0d want %0d", bus_log.size() - idx0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (idx0 + i >= bus_log.size()) begin n_fail++; $display("FAIL bottom_seq[%0d] got none want %h", i, exp[i]); end
      else if (bus_log[idx0 + i] !== exp[i]) begin n_fail++; $display("FAIL bottom_seq[%0d] got %h want %h", i, bus_log[idx0 + i], exp[i]); end
    end
  endtask

  task automatic test_erase();
    logic [8:0] exp[$];
    int idx0;
    bit to;
    exp = '{9'h082, 9'h120, 9'h083, 9'h120, 9'h084, 9'h120,
            9'h0C2, 9'h120, 9'h0C3, 9'h120, 9'h0C4, 9'h120,
            9'h083, 9'h100, 9'h084, 9'h101, 9'h085, 9'h102,
            9'h0C3, 9'h103, 9'h0C4, 9'h104, 9'h0C5, 9'h105};
    request(4'd2, 1'b0, 8'h00, 1'b1, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL erase_pre_timeout got 0 want 1"); end
    idx0 = bus_log.size();
    request(4'd3, 1'b0, 8'h00, 1'b0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL erase_done_timeout got 0 want 1"); end
    @(negedge clk);
    n_tests++; if (bus_log.size() - idx0 != exp.size()) begin n_fail++; $display("FAIL erase_len got %0d want %0d", bus_log.size() - idx0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (idx0 + i >= bus_log.size()) begin n_fail++; $display("FAIL erase_seq[%0d] got none want %h", i, exp[i]); end
      else if (bus_log[idx0 + i] !== exp[i]) begin n_fail++; $display("FAIL erase_seq[%0d] got %h want %h", i, bus_log[idx0 + i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp[$];
    int idx0, d0;
    bit seen;
    exp = '{9'h001, 9'h085, 9'h130, 9'h086, 9'h131, 9'h087, 9'h132,
            9'h0C5, 9'h133, 9'h0C6, 9'h134, 9'h0C7, 9'h135};
    idx0 = bus_log.size(); d0 = done_cnt;
    @(negedge clk);
    col = 4'd5; row = 1'b0; base_char = 8'h30; clear_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    col = 4'd9; base_char = 8'h77; clear_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL b2b_done_timeout got 0 want 1"); end
    repeat (60) @(negedge clk);
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got %b want 0", busy); end
    n_tests++; if (bus_log.size() - idx0 != exp.size()) begin n_fail++; $display("FAIL b2b_len got %0d want %0d", bus_log.size() - idx0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (idx0 + i >= bus_log.size()) begin n_fail++; $display("FAIL b2b_seq[%0d] got none want %h", i, exp[i]); end
      else if (bus_log[idx0 + i] !== exp[i]) begin n_fail++; $display("FAIL b2b_seq[%0d] got %h want %h", i, bus_log[idx0 + i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp[$];
    int idx0;
    bit seen, to;
    exp = '{9'h038, 9'h00C, 9'h006, 9'h080, 9'h100, 9'h081, 9'h101,
            9'h082, 9'h102, 9'h0C0, 9'h103, 9'h0C1, 9'h104, 9'h0C2, 9'h105};
    @(negedge clk);
    col = 4'd0; row = 1'b0; base_char = 8'h00; clear_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (lcd_en && lcd_rs) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rmid_no_data_strobe got 0 want 1"); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_en got %b want 0", lcd_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_tests++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h want 00", lcd_data); end
    n_tests++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL rmid_rs got %b want 0", lcd_rs); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b want 0", done); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idx0 = bus_log.size();
    request(4'd0, 1'b0, 8'h00, 1'b0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rmid_done_timeout got 0 want 1"); end
    @(negedge clk);
    n_tests++; if (bus_log.size() - idx0 != exp.size()) begin n_fail++; $display("FAIL rmid_len got %0d want %0d", bus_log.size() - idx0, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (idx0 + i >= bus_log.size()) begin n_fail++; $display("FAIL rmid_seq[%0d] got none want %h", i, exp[i]); end
      else if (bus_log[idx0 + i] !== exp[i]) begin n_fail++; $display("FAIL rmid_seq[%0d] got %h want %h", i, bus_log[idx0 + i], exp[i]); end
    end
  endtask

  // Slow instance: EN_HOLD=3, CMD_WAIT=5, CLEAR_WAIT=4.
  task automatic test_timing();
    logic [7:0] init_cmds[4];
    logic [7:0] pdata, dprev;
    logic prs, en_p;
    int cyc, rises, hi, post, last_rise, need, lim;
    bit seen;
    init_cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    cyc = 0; rises = 0; hi = 0; post = 0; last_rise = 0;
    pdata = 8'h00; prs = 1'b0; en_p = 1'b0; dprev = data2;
    @(negedge clk);
    col = 4'd0; row = 1'b0; base_char = 8'h00; clear_mode = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (done2) seen = 1'b1;
      lim = (pdata == 8'h01 && !prs) ? 4 : 5;
      if (en2 && !en_p) begin
        rises++;
        n_tests++; if (data2 !== dprev) begin n_fail++; $display("FAIL t_setup rise %0d got %h want %h", rises, dprev, data2); end
        if (rises <= 4) begin
          n_tests++; if (data2 !== init_cmds[rises-1] || rs2 !== 1'b0) begin n_fail++; $display("FAIL t_cmd rise %0d got %h want %h", rises, data2, init_cmds[rises-1]); end
        end
        if (rises > 1) begin
          need = 1 + 3 + lim;
          n_tests++; if (cyc - last_rise < need) begin n_fail++; $display("FAIL t_gap rise %0d got %0d want >=%0d", rises, cyc - last_rise, need); end
          if (rises <= 3) begin
            n_tests++; if (cyc - last_rise != 9) begin n_fail++; $display("FAIL t_init_gap rise %0d got %0d want 9", rises, cyc - last_rise); end
          end
        end
        last_rise = cyc; pdata = data2; prs = rs2; hi = 1; post = 0;
      end else if (en2) begin
        hi++;
        n_tests++; if (data2 !== pdata) begin n_fail++; $display("FAIL t_hold_data got %h want %h", data2, pdata); end
      end else if (en_p) begin
        n_tests++; if (hi != 3) begin n_fail++; $display("FAIL t_width got %0d want 3", hi); end
        n_tests++; if (data2 !== pdata) begin n_fail++; $display("FAIL t_fall_data got %h want %h", data2, pdata); end
        post = 1;
      end else if (post > 0 && post < lim) begin
        post++;
        n_tests++; if (data2 !== pdata || rs2 !== prs) begin n_fail++; $display("FAIL t_wait_data got %h want %h", data2, pdata); end
      end
      en_p = en2; dprev = data2;
      if (seen) break;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL t_done_timeout got 0 want 1"); end
    n_tests++; if (rises != 16) begin n_fail++; $display("FAIL t_strobe_count got %0d want 16", rises); end
    n_tests++; if (busy2 !== 1'b0 || rw2 !== 1'b0) begin n_fail++; $display("FAIL t_busy_rw got %b%b want 00", busy2, rw2); end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_edge_clip();
    test_bottom_clip();
    test_erase();
    test_back_to_back();
    test_reset_mid();
    test_timing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
